hilo_muldiv_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the 5-stage MIPS pipeline. Runs MULT/MULTU on an iterative radix-2 multiplier in the EX stage, serves MFHI/MFLO/MTHI/MTLO, and raises a stall request to the hazard unit while a product is pending. HI/LO update in place, so no EX/Mem/Wr forwarding of HI/LO is needed downstream.

---
 rtl/hilo_pkg.sv | 31 +++
 rtl/hilo_muldiv_ctrl_if.sv | 27 ++
 rtl/seq_multiplier.sv | 80 ++++++++
 rtl/hilo_muldiv_ctrl.sv | 86 ++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared decode constants, FSM state type and HI/LO instruction classifier
// for the MIPS HI/LO multiply/divide controller.
package hilo_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic is_hilo_instr(input logic [5:0] op, input logic [5:0] func);
    logic hit;
    hit = 1'b0;
    if (op == OP_SPECIAL) begin
      case (func)
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU: hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Pipeline-facing bundle of the HI/LO controller: EX/ID decode inputs,
// HI/LO read data and stall/status outputs.
interface hilo_muldiv_ctrl_if #(parameter int DATA_W = 32);
  logic              ex_valid;
  logic [5:0]        ex_op;
  logic [5:0]        ex_func;
  logic [DATA_W-1:0] ex_rs;
  logic [DATA_W-1:0] ex_rt;
  logic [5:0]        id_op;
  logic [5:0]        id_func;
  logic [DATA_W-1:0] hilo_rdata;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              busy;
  logic              stall_req;
  logic              mul_done;

  modport master (
    output ex_valid, ex_op, ex_func, ex_rs, ex_rt, id_op, id_func,
    input  hilo_rdata, hi_o, lo_o, busy, stall_req, mul_done
  );

  modport slave (
    input  ex_valid, ex_op, ex_func, ex_rs, ex_rt, id_op, id_func,
    output hilo_rdata, hi_o, lo_o, busy, stall_req, mul_done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned DATA_W x DATA_W radix-2 shift-add multiplier, one partial
// product per cycle; product is valid in the cycle done is high.
//
// state | meaning
// IDLE  | waiting for start, operands latched on start
// BUSY  | one shift-add step per cycle, DATA_W steps total
module seq_multiplier
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(DATA_W - 2);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [2*DATA_W-1:0]  mcand_q;
  logic [DATA_W-1:0]    mplier_q;
  logic [2*DATA_W-1:0]  acc_q;
  logic                 done_q;
  logic [2*DATA_W-1:0]  acc_next;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (count_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      // done is registered one step early so it lines up with the final step
      done_q <= (state_q == BUSY) && (count_q == CNT_PENULT);
      if (state_q == IDLE) begin
        if (start) begin
          count_q  <= '0;
          mcand_q  <= {{DATA_W{1'b0}}, a};
          mplier_q <= b;
          acc_q    <= '0;
        end
      end else begin
        count_q  <= count_q + 1'b1;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_next;
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = done_q;
  assign product = acc_next;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner for the 5-stage pipeline: sequences MULT/MULTU on the
// shift-add core, serves MFHI/MFLO/MTHI/MTLO and requests stalls for HI/LO users.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  hilo_muldiv_ctrl_if.slave bus
);

  logic                 ex_special;
  logic                 ex_mult, ex_multu, ex_mfhi, ex_mflo, ex_mthi, ex_mtlo;
  logic                 id_hilo;
  logic                 mul_busy, mul_done;
  logic                 start;
  logic [DATA_W-1:0]    op_a, op_b;
  logic [2*DATA_W-1:0]  mul_product;
  logic [2*DATA_W-1:0]  result;
  logic                 sign_q;
  logic [DATA_W-1:0]    hi_q, lo_q;

  assign ex_special = bus.ex_valid && (bus.ex_op == OP_SPECIAL);
  assign ex_mult    = ex_special && (bus.ex_func == FN_MULT);
  assign ex_multu   = ex_special && (bus.ex_func == FN_MULTU);
  assign ex_mfhi    = ex_special && (bus.ex_func == FN_MFHI);
  assign ex_mflo    = ex_special && (bus.ex_func == FN_MFLO);
  assign ex_mthi    = ex_special && (bus.ex_func == FN_MTHI);
  assign ex_mtlo    = ex_special && (bus.ex_func == FN_MTLO);
  assign id_hilo    = is_hilo_instr(bus.id_op, bus.id_func);

  // a start seen while busy is dropped by the core, so gate it here too
  assign start = !rst && !mul_busy && (ex_mult || ex_multu);

  // magnitude of the most negative operand still fits as DATA_W unsigned
  assign op_a = (ex_mult && bus.ex_rs[DATA_W-1]) ? (~bus.ex_rs + 1'b1) : bus.ex_rs;
  assign op_b = (ex_mult && bus.ex_rt[DATA_W-1]) ? (~bus.ex_rt + 1'b1) : bus.ex_rt;

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst)        sign_q <= 1'b0;
    else if (start) sign_q <= ex_mult && (bus.ex_rs[DATA_W-1] ^ bus.ex_rt[DATA_W-1]);
  end

  assign result = sign_q ? (~mul_product + 1'b1) : mul_product;

  // the product overrides a same-cycle MTHI/MTLO issued in violation of the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mul_done) begin
      hi_q <= result[2*DATA_W-1:DATA_W];
      lo_q <= result[DATA_W-1:0];
    end else begin
      if (ex_mthi) hi_q <= bus.ex_rs;
      if (ex_mtlo) lo_q <= bus.ex_rs;
    end
  end

  always_comb begin
    bus.hilo_rdata = '0;
    if (!rst) begin
      if (ex_mfhi)      bus.hilo_rdata = hi_q;
      else if (ex_mflo) bus.hilo_rdata = lo_q;
    end
  end

  assign bus.stall_req = !rst && id_hilo && (mul_busy || start);
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.busy      = mul_busy;
  assign bus.mul_done  = mul_done;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: multiply timing, signed corner cases,
// stall behaviour, MTHI/MTLO read-after-write and reset abandonment.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam logic [5:0] FN_ADD = 6'b100000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hilo_muldiv_ctrl_if #(.DATA_W(32)) bus ();

  hilo_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    bus.ex_valid = v;
    bus.ex_op    = OP_SPECIAL;
    bus.ex_func  = f;
    bus.ex_rs    = rs;
    bus.ex_rt    = rt;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] f);
    bus.id_op   = op;
    bus.id_func = f;
  endtask

  // Starts a multiply in the current cycle N, bubbles EX afterwards and
  // returns in cycle N+33 with the product expected on hi_o/lo_o.
  task automatic run_mul(input string tag, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [5:0] idf,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_stalls);
    int stalls, busy_cnt, done_cnt, done_at;
    stalls = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    set_ex(1'b1, f, rs, rt);
    set_id(OP_SPECIAL, idf);
    #1;
    chk({tag, "_idle_at_start"}, {63'd0, bus.busy}, 64'd0);
    if (bus.stall_req) stalls++;
    for (int k = 1; k <= 32; k++) begin
      step();
      set_ex(1'b0, FN_ADD, 32'd0, 32'd0);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.stall_req) stalls++;
      if (bus.mul_done) begin
        done_cnt++;
        done_at = k;
      end
    end
    step();
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_at), 64'd32);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    chk({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_stall_after"}, {63'd0, bus.stall_req}, 64'd0);
    chk({tag, "_hi"}, {32'd0, bus.hi_o}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, bus.lo_o}, {32'd0, exp_lo});
  endtask

  always @(posedge clk) begin
    if (!rst && bus.busy && bus.ex_valid && bus.ex_op == OP_SPECIAL &&
        (bus.ex_func == FN_MULT || bus.ex_func == FN_MULTU))
      chk("start_while_busy", 64'd1, 64'd0);
  end

  initial begin
    int pulses;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_ex(1'b0, FN_ADD, 32'd0, 32'd0);
    set_id(OP_SPECIAL, FN_ADD);
    step();
    step();
    set_id(OP_SPECIAL, FN_MFLO);
    set_ex(1'b1, FN_MULT, 32'd3, 32'd4);
    #1;
    chk("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.mul_done}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall_req}, 64'd0);
    chk("rst_rdata", {32'd0, bus.hilo_rdata}, 64'd0);
    set_ex(1'b0, FN_ADD, 32'd0, 32'd0);
    set_id(OP_SPECIAL, FN_ADD);
    step();
    rst = 1'b0;
    step();

    // unsigned max squared, ADD in ID never stalls
    run_mul("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_ADD,
            32'hFFFF_FFFE, 32'h0000_0001, 0);
    step();

    // -2^31 x -1, then -3 x 7 back-to-back with MFLO waiting in ID
    run_mul("mult_minneg", FN_MULT, 32'h8000_0000, 32'hFFFF_FFFF, FN_ADD,
            32'h0000_0000, 32'h8000_0000, 0);
    run_mul("mult_m3x7", FN_MULT, 32'hFFFF_FFFD, 32'd7, FN_MFLO,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    set_ex(1'b1, FN_MFLO, 32'd0, 32'd0);
    set_id(OP_SPECIAL, FN_ADD);
    #1;
    chk("mflo_after_stall", {32'd0, bus.hilo_rdata}, 64'h0000_0000_FFFF_FFEB);
    step();

    // MTHI then MFHI next cycle, no stall
    set_ex(1'b1, FN_MTHI, 32'h1234_5678, 32'd0);
    set_id(OP_SPECIAL, FN_MFHI);
    #1;
    chk("mthi_stall", {63'd0, bus.stall_req}, 64'd0);
    step();
    set_ex(1'b1, FN_MFHI, 32'd0, 32'd0);
    set_id(OP_SPECIAL, FN_MTLO);
    #1;
    chk("mfhi_rdata", {32'd0, bus.hilo_rdata}, 64'h0000_0000_1234_5678);
    chk("mfhi_stall", {63'd0, bus.stall_req}, 64'd0);
    step();
    set_ex(1'b1, FN_MTLO, 32'hCAFE_0001, 32'd0);
    set_id(OP_SPECIAL, FN_MFLO);
    #1;
    chk("mtlo_stall", {63'd0, bus.stall_req}, 64'd0);
    step();
    set_ex(1'b1, FN_MFLO, 32'd0, 32'd0);
    set_id(OP_SPECIAL, FN_ADD);
    #1;
    chk("mflo_rdata", {32'd0, bus.hilo_rdata}, 64'h0000_0000_CAFE_0001);
    step();

    // MULT func with ex_valid low is not a start
    set_ex(1'b0, FN_MULT, 32'd9, 32'd9);
    set_id(OP_SPECIAL, FN_MFLO);
    #1;
    chk("novalid_stall", {63'd0, bus.stall_req}, 64'd0);
    chk("novalid_rdata", {32'd0, bus.hilo_rdata}, 64'd0);
    step();
    chk("novalid_busy", {63'd0, bus.busy}, 64'd0);

    // reset at N+10 abandons the product
    set_ex(1'b1, FN_MULT, 32'd7, 32'd9);
    set_id(OP_SPECIAL, FN_ADD);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      set_ex(1'b0, FN_ADD, 32'd0, 32'd0);
      #1;
      if (bus.mul_done) pulses++;
      if (k == 5) chk("busy_mid_mul", {63'd0, bus.busy}, 64'd1);
      if (k == 5) chk("add_in_id_no_stall", {63'd0, bus.stall_req}, 64'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rstmid_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rstmid_lo", {32'd0, bus.lo_o}, 64'd0);
    for (int k = 0; k < 30; k++) begin
      if (bus.mul_done) pulses++;
      step();
    end
    chk("rstmid_no_done", 64'(pulses), 64'd0);

    run_mul("mult_5x6", FN_MULT, 32'd5, 32'd6, FN_ADD, 32'd0, 32'd30, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
